tlul_mem_responder: RTL and testbench
=====================================

TLUL_MEM_RESPONDER -- requirements
Module: tlul_mem_responder

Interface
REQ-001 SHALL have parameter MemDepth, default 256, meaning number of TL_DW-wide storage words.
REQ-002 SHALL have parameter BaseAddr, default 32'h0000_0000, meaning byte address of word 0.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tl_i  input  tl_h2d_t  host-to-device A channel plus d_ready.
REQ-006 SHALL have port tl_o  output  tl_d2h_t  device-to-host D channel plus a_ready.

Function
REQ-007 SHALL contain MemDepth x TL_DW storage, word index = (a_address - BaseAddr) >> log2(TL_DBW).
REQ-008 SHALL implement FSM states IDLE (no response held) and RSP (response held on D).
REQ-009 SHALL drive a_ready = 1 in IDLE, and in RSP only when d_ready = 1 (same-cycle accept of next request).
REQ-010 SHALL accept a request when a_valid && a_ready, and SHALL assert d_valid in the following cycle (latency 1).
REQ-011 SHALL hold every d_* field stable while d_valid && !d_ready.
REQ-012 SHALL leave RSP for IDLE on d_ready with no new accept, and SHALL stay in RSP with the new response on d_ready plus accept.
REQ-013 SHALL echo d_source = a_source and d_size = a_size, and SHALL drive d_param = 0 and d_sink = 0.
REQ-014 Get SHALL return d_opcode AccessAckData with d_data = stored word (all bytes, regardless of mask).
REQ-015 PutFullData SHALL write all bytes and PutPartialData SHALL write only bytes with a_mask bit set; both SHALL return AccessAck with d_data = 0.
REQ-016 SHALL flag d_error = 1 on: opcode not in {0,1,4}; address below BaseAddr or word index >= MemDepth; a_size > log2(TL_DBW); address not aligned to 2^a_size.
REQ-017 SHALL flag d_error = 1 for PutFullData whose a_mask is not all-ones over the addressed 2^a_size bytes.
REQ-018 An erroring request SHALL NOT modify storage, SHALL return d_data = 0, and SHALL use AccessAckData for Get, AccessAck otherwise.
REQ-019 A write and a subsequent read of the same word accepted one cycle later SHALL return the new data (no stale read).
REQ-020 d_valid SHALL never assert without a prior accepted request; no request SHALL be dropped or duplicated.

Reset
REQ-021 On rst_i = 1, SHALL asynchronously enter IDLE with d_valid = 0, a_ready = 0 during reset, all other d_* fields 0.
REQ-022 a_ready SHALL rise to 1 in the first cycle after rst_i deasserts.
REQ-023 Reset mid-response SHALL discard the held response; storage contents are undefined after reset (no clear required).

Structure
REQ-024 tl_h2d_t, tl_d2h_t, tl_a_op_e, tl_d_op_e SHALL come from tlul_pkg; TL_AW/DW/AIW/DIW/SZW/DBW from top_pkg; no new typedefs in the module.
REQ-025 SHALL split out one sub-module, tlul_req_check, purely combinational, producing the error flag and word index from the A channel.

Verification
REQ-026 PutFullData addr 0x0, mask 0xF, data 0xDEADBEEF, source 5 -> next cycle d_valid, AccessAck, d_source 5, d_error 0; then Get 0x0 -> AccessAckData, d_data 0xDEADBEEF.
REQ-027 PutPartialData addr 0x4 mask 0x2 data 0x0000AB00 over stored 0x11223344 -> Get 0x4 returns 0x1122AB44.
REQ-028 Get at word index MemDepth (0x400 with defaults) -> d_error 1, d_data 0, AccessAckData; storage unchanged.
REQ-029 d_ready held 0 for 4 cycles after a Get -> d_* stable, a_ready 0; d_ready 1 with a_valid 1 same cycle -> new request accepted, d_valid stays 1 with new response next cycle.
REQ-030 Opcode 3'h2, and a_size 2 at addr 0x2 -> both d_error 1, no storage write; rst_i pulsed while d_valid 1 -> d_valid 0 immediately, a_ready 1 first cycle after release.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL channel bundles, opcodes and the responder state encoding.
package tlul_pkg;
  import top_pkg::*;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RSP  = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/top_pkg.sv
// Bus geometry shared by every TL-UL block in this slice.
package top_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;
endpackage

// File: rtl/tlul_req_check.sv
// A-channel legality check and word index, purely combinational.
module tlul_req_check
  import top_pkg::*;
  import tlul_pkg::*;
#(
  parameter int              MemDepth = 256,
  parameter logic [TL_AW-1:0] BaseAddr = 32'h0000_0000,
  parameter int              IdxW     = 8
) (
  input  tl_a_op_e          a_opcode,
  input  logic [TL_SZW-1:0] a_size,
  input  logic [TL_AW-1:0]  a_address,
  input  logic [TL_DBW-1:0] a_mask,
  output logic              err,
  output logic [IdxW-1:0]   idx
);
  localparam int OffW = $clog2(TL_DBW);

  logic [TL_AW-1:0]  off;
  logic [TL_AW-1:0]  widx;
  logic [OffW-1:0]   lo;
  logic [OffW-1:0]   amask;
  logic [TL_DBW-1:0] lanes;
  logic [TL_DBW-1:0] need;
  logic              op_bad;
  logic              rng_bad;
  logic              sz_bad;
  logic              aln_bad;
  logic              msk_bad;

  always_comb begin
    off  = a_address - BaseAddr;
    widx = off >> OffW;
    lo   = a_address[OffW-1:0];
    for (int i = 0; i < OffW; i++) begin
      amask[i] = 32'(i) < 32'(a_size);
    end
    // lanes = the low 2^a_size byte lanes, then moved to the address offset
    for (int i = 0; i < TL_DBW; i++) begin
      lanes[i] = (32'(i) >> a_size) == 32'd0;
    end
    need    = lanes << lo;
    op_bad  = !(a_opcode inside {PutFullData, PutPartialData, Get});
    rng_bad = (a_address < BaseAddr) ||
              (widx >= TL_AW'(MemDepth));
    sz_bad  = 32'(a_size) > 32'(OffW);
    aln_bad = |(lo & amask);
    msk_bad = (a_opcode == PutFullData) &&
              ((a_mask & need) != need);
    err = op_bad | rng_bad | sz_bad | aln_bad | msk_bad;
    idx = widx[IdxW-1:0];
  end
endmodule

// File: rtl/tlul_mem_responder.sv
// Single-outstanding TL-UL memory slave with a registered D channel.
module tlul_mem_responder
  import top_pkg::*;
  import tlul_pkg::*;
#(
  parameter int              MemDepth = 256,
  parameter logic [TL_AW-1:0] BaseAddr = 32'h0000_0000
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o
);
  localparam int IdxW = (MemDepth > 1) ? $clog2(MemDepth) : 1;

  rsp_state_e        state_q;
  logic              a_ready;
  logic              accept;
  logic              err;
  logic              is_get;
  logic              we;
  logic [IdxW-1:0]   idx;
  logic [TL_DBW-1:0] be;
  logic [TL_DW-1:0]  mem [MemDepth];

  logic              d_valid_q;
  tl_d_op_e          d_opcode_q;
  logic [TL_SZW-1:0] d_size_q;
  logic [TL_AIW-1:0] d_source_q;
  logic [TL_DW-1:0]  d_data_q;
  logic              d_error_q;
  logic              unused_a_param;

  assign unused_a_param = ^tl_i.a_param;

  tlul_req_check #(
    .MemDepth (MemDepth),
    .BaseAddr (BaseAddr),
    .IdxW     (IdxW)
  ) u_check (
    .a_opcode  (tl_i.a_opcode),
    .a_size    (tl_i.a_size),
    .a_address (tl_i.a_address),
    .a_mask    (tl_i.a_mask),
    .err       (err),
    .idx       (idx)
  );

  // Held response may be replaced in the same cycle it is consumed
  assign a_ready = !rst_i &&
                   ((state_q == IDLE) || tl_i.d_ready);
  assign accept  = tl_i.a_valid && a_ready;
  assign is_get  = tl_i.a_opcode == Get;
  assign we      = accept && !err && !is_get;
  assign be      = (tl_i.a_opcode == PutFullData) ?
                   '1 : tl_i.a_mask;

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < TL_DBW; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      d_valid_q  <= 1'b0;
      d_opcode_q <= AccessAck;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else if (accept) begin
      state_q    <= RSP;
      d_valid_q  <= 1'b1;
      d_opcode_q <= is_get ? AccessAckData : AccessAck;
      d_size_q   <= tl_i.a_size;
      d_source_q <= tl_i.a_source;
      d_data_q   <= (is_get && !err) ? mem[idx] : '0;
      d_error_q  <= err;
    end else if (tl_i.d_ready) begin
      state_q   <= IDLE;
      d_valid_q <= 1'b0;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid_q;
    tl_o.d_opcode = d_opcode_q;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_data   = d_data_q;
    tl_o.d_error  = d_error_q;
    tl_o.a_ready  = a_ready;
  end
endmodule

// File: tb/tb_tlul_mem_responder.sv
// Random and directed stimulus against a transaction-level memory model.
module tb_tlul_mem_responder;
  import top_pkg::*;
  import tlul_pkg::*;

  localparam int DEPTH = 256;

  logic    clk;
  logic    rst;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;

  int vectors;
  int miscompares;

  bit [31:0] mem_m [DEPTH];
  bit        known [DEPTH];
  bit        held;
  bit [2:0]  e_op;
  bit [1:0]  e_sz;
  bit [7:0]  e_src;
  bit        e_err;
  bit [31:0] e_data;
  bit        e_dknown;

  tlul_mem_responder #(
    .MemDepth (DEPTH),
    .BaseAddr (32'h0)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .tl_i  (tl_i),
    .tl_o  (tl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic bit m_err(bit [2:0] op, bit [31:0] addr,
                               bit [1:0] sz, bit [3:0] mask);
    int nb;
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1;
    if (addr / 4 >= DEPTH) return 1;
    if (sz > 2) return 1;
    nb = 1 << sz;
    if (addr % nb != 0) return 1;
    if (op == 3'd0)
      for (int b = 0; b < nb; b++)
        if (!mask[addr % 4 + b]) return 1;
    return 0;
  endfunction

  // Model: one response slot, refilled whenever the bench sees an accept
  always @(negedge clk) begin
    bit [2:0]  op;
    bit [31:0] w;
    bit        exp_ar;
    if (rst) begin
      chk("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
      chk("rst_a_ready", 32'(tl_o.a_ready), 32'd0);
      held = 0;
      for (int i = 0; i < DEPTH; i++) known[i] = 0;
    end else begin
      exp_ar = !held || tl_i.d_ready;
      chk("a_ready", 32'(tl_o.a_ready), 32'(exp_ar));
      chk("d_valid", 32'(tl_o.d_valid), 32'(held));
      if (held) begin
        chk("d_opcode", 32'(tl_o.d_opcode), 32'(e_op));
        chk("d_size", 32'(tl_o.d_size), 32'(e_sz));
        chk("d_source", 32'(tl_o.d_source), 32'(e_src));
        chk("d_error", 32'(tl_o.d_error), 32'(e_err));
        chk("d_param_sink",
            32'({tl_o.d_param, tl_o.d_sink}), 32'd0);
        if (e_dknown) chk("d_data", tl_o.d_data, e_data);
      end
      if (tl_i.a_valid && exp_ar) begin
        op       = tl_i.a_opcode;
        w        = tl_i.a_address / 4;
        e_op     = (op == 3'd4) ? 3'd1 : 3'd0;
        e_sz     = tl_i.a_size;
        e_src    = tl_i.a_source;
        e_err    = m_err(op, tl_i.a_address, tl_i.a_size,
                         tl_i.a_mask);
        e_data   = 0;
        e_dknown = 1;
        if (!e_err && op == 3'd4) begin
          if (known[w]) e_data = mem_m[w];
          else e_dknown = 0;
        end
        if (!e_err && op == 3'd0) begin
          mem_m[w] = tl_i.a_data;
          known[w] = 1;
        end
        if (!e_err && op == 3'd1)
          for (int b = 0; b < 4; b++)
            if (tl_i.a_mask[b])
              mem_m[w][8*b +: 8] = tl_i.a_data[8*b +: 8];
        held = 1;
      end else if (tl_i.d_ready) begin
        held = 0;
      end
    end
  end

  task automatic drive(bit [2:0] op, bit [31:0] addr,
                       bit [1:0] sz, bit [3:0] mask,
                       bit [31:0] data, bit [7:0] src);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = tl_a_op_e'(op);
    tl_i.a_param   = 3'd0;
    tl_i.a_size    = sz;
    tl_i.a_source  = src;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    tl_i.d_ready   = 1'b1;
  endtask

  task automatic req(bit [2:0] op, bit [31:0] addr,
                     bit [1:0] sz, bit [3:0] mask,
                     bit [31:0] data, bit [7:0] src);
    @(posedge clk); #1;
    drive(op, addr, sz, mask, data, src);
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
  endtask

  task automatic rand_req();
    bit [2:0]  op;
    bit [1:0]  sz;
    bit [31:0] addr;
    bit [3:0]  mask;
    int        r;
    r  = $urandom_range(0, 99);
    op = (r < 10) ? 3'($urandom_range(0, 7)) :
         (r < 40) ? 3'd0 : (r < 60) ? 3'd1 : 3'd4;
    sz = ($urandom_range(0, 99) < 70) ? 2'd2 :
         2'($urandom_range(0, 3));
    r  = $urandom_range(0, 99);
    if (r < 80) addr = 32'($urandom_range(0, 15)) * 4 +
                       32'($urandom_range(0, 3));
    else if (r < 90) addr = 32'h400 + 32'($urandom_range(0, 63));
    else addr = $urandom;
    if (sz <= 2 && $urandom_range(0, 99) < 80)
      addr = addr & ~((32'd1 << sz) - 1);
    mask = 4'($urandom);
    if ($urandom_range(0, 1) == 1 && sz <= 2)
      mask = 4'(((1 << (1 << sz)) - 1) << (addr % 4));
    drive(op, addr, sz, mask, $urandom, 8'($urandom));
    tl_i.a_valid = $urandom_range(0, 99) < 70;
    tl_i.d_ready = $urandom_range(0, 99) < 70;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    held        = 0;
    rst         = 1'b1;
    tl_i        = '0;
    tl_i.d_ready = 1'b1;
    #12;
    chk("rst_fields", 32'({tl_o.d_opcode, tl_o.d_size,
        tl_o.d_source, tl_o.d_error}), 32'd0);
    chk("rst_data", tl_o.d_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("a_ready_after_rst", 32'(tl_o.a_ready), 32'd1);

    for (int i = 0; i < DEPTH; i++)
      req(3'd0, 32'(i) * 4, 2'd2, 4'hF, $urandom, 8'(i));

    req(3'd0, 32'h0, 2'd2, 4'hF, 32'hDEADBEEF, 8'd5);
    chk("pf_valid", 32'(tl_o.d_valid), 32'd1);
    chk("pf_opcode", 32'(tl_o.d_opcode), 32'(AccessAck));
    chk("pf_source", 32'(tl_o.d_source), 32'd5);
    chk("pf_error", 32'(tl_o.d_error), 32'd0);
    req(3'd4, 32'h0, 2'd2, 4'h0, 32'h0, 8'd1);
    chk("get0_opcode", 32'(tl_o.d_opcode),
        32'(AccessAckData));
    chk("get0_data", tl_o.d_data, 32'hDEADBEEF);

    req(3'd0, 32'h4, 2'd2, 4'hF, 32'h11223344, 8'd2);
    req(3'd1, 32'h4, 2'd2, 4'h2, 32'h0000AB00, 8'd2);
    req(3'd4, 32'h4, 2'd2, 4'hF, 32'h0, 8'd2);
    chk("partial_data", tl_o.d_data, 32'h1122AB44);

    req(3'd4, 32'h400, 2'd2, 4'hF, 32'h0, 8'd4);
    chk("oor_error", 32'(tl_o.d_error), 32'd1);
    chk("oor_data", tl_o.d_data, 32'd0);
    chk("oor_opcode", 32'(tl_o.d_opcode),
        32'(AccessAckData));
    req(3'd0, 32'h400, 2'd2, 4'hF, 32'h55555555, 8'd4);
    chk("oor_put_error", 32'(tl_o.d_error), 32'd1);
    req(3'd2, 32'h0, 2'd2, 4'hF, 32'h0, 8'd6);
    chk("badop_error", 32'(tl_o.d_error), 32'd1);
    chk("badop_opcode", 32'(tl_o.d_opcode), 32'(AccessAck));
    req(3'd0, 32'h2, 2'd2, 4'hF, 32'h0, 8'd6);
    chk("misalign_error", 32'(tl_o.d_error), 32'd1);
    req(3'd4, 32'h0, 2'd2, 4'hF, 32'h0, 8'd6);
    chk("word0_intact", tl_o.d_data, 32'hDEADBEEF);

    req(3'd4, 32'h0, 2'd2, 4'hF, 32'h0, 8'd3);
    drive(3'd4, 32'h8, 2'd2, 4'hF, 32'h0, 8'd7);
    tl_i.d_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_valid", 32'(tl_o.d_valid), 32'd1);
      chk("stall_data", tl_o.d_data, 32'hDEADBEEF);
      chk("stall_source", 32'(tl_o.d_source), 32'd3);
      chk("stall_a_ready", 32'(tl_o.a_ready), 32'd0);
      @(posedge clk); #1;
    end
    drive(3'd4, 32'h4, 2'd2, 4'hF, 32'h0, 8'd9);
    #1 chk("release_a_ready", 32'(tl_o.a_ready), 32'd1);
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    chk("b2b_valid", 32'(tl_o.d_valid), 32'd1);
    chk("b2b_source", 32'(tl_o.d_source), 32'd9);
    chk("b2b_data", tl_o.d_data, 32'h1122AB44);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rand_req();
    end
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    tl_i.d_ready = 1'b1;
    repeat (2) @(posedge clk);

    req(3'd4, 32'h0, 2'd2, 4'hF, 32'h0, 8'd8);
    tl_i.d_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk("midrst_valid", 32'(tl_o.d_valid), 32'd0);
    chk("midrst_a_ready", 32'(tl_o.a_ready), 32'd0);
    chk("midrst_data", tl_o.d_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("post_rst_a_ready", 32'(tl_o.a_ready), 32'd1);
    chk("post_rst_valid", 32'(tl_o.d_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
